// File: rtl/fp16_divider.sv
// Multi-cycle IEEE fp16 divider: restoring significand division (one quotient bit
// per cycle), round-to-nearest-even, subnormal flush, fixed latency for all operands.
module fp16_divider (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [11:0] r_rem;
  logic [10:0] r_div;
  logic [12:0] r_q;
  logic [3:0]  r_cnt;
  logic [15:0] r_out;

  // Restoring step: partial remainder stays below 2*divisor, so 12 bits suffice.
  logic        w_ge;
  logic [11:0] w_diff;
  logic [11:0] w_sel;
  logic [11:0] w_rem_next;

  assign w_ge       = (r_rem >= {1'b0, r_div});
  assign w_diff     = r_rem - {1'b0, r_div};
  assign w_sel      = w_ge ? w_diff : r_rem;
  assign w_rem_next = {w_sel[10:0], 1'b0};

  logic [4:0]        w_ea;
  logic [4:0]        w_eb;
  logic              w_sign;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [9:0]        w_man;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [10:0]       w_man_sum;
  logic [9:0]        w_man_rnd;
  logic signed [7:0] w_exp;
  logic signed [7:0] w_exp_rnd;
  logic [15:0]       w_result;

  assign w_ea     = r_a[14:10];
  assign w_eb     = r_b[14:10];
  assign w_sign   = r_a[15] ^ r_b[15];
  assign w_a_zero = (w_ea == 5'd0);
  assign w_b_zero = (w_eb == 5'd0);
  assign w_a_inf  = (w_ea == 5'd31) && (r_a[9:0] == 10'd0);
  assign w_b_inf  = (w_eb == 5'd31) && (r_b[9:0] == 10'd0);
  assign w_a_nan  = (w_ea == 5'd31) && (r_a[9:0] != 10'd0);
  assign w_b_nan  = (w_eb == 5'd31) && (r_b[9:0] != 10'd0);

  always_comb begin
    w_man     = 10'd0;
    w_guard   = 1'b0;
    w_sticky  = 1'b0;
    w_exp     = 8'sd0;
    w_inc     = 1'b0;
    w_man_sum = 11'd0;
    w_man_rnd = 10'd0;
    w_exp_rnd = 8'sd0;
    w_result  = 16'h0000;

    if (r_q[12]) begin
      w_man    = r_q[11:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (r_rem != 12'd0);
      w_exp    = $signed({3'b000, w_ea}) - $signed({3'b000, w_eb}) + 8'sd15;
    end else begin
      w_man    = r_q[10:1];
      w_guard  = r_q[0];
      w_sticky = (r_rem != 12'd0);
      w_exp    = $signed({3'b000, w_ea}) - $signed({3'b000, w_eb}) + 8'sd14;
    end

    w_inc     = w_guard & (w_sticky | w_man[0]);
    w_man_sum = {1'b0, w_man} + {10'd0, w_inc};
    if (w_man_sum[10]) begin
      w_man_rnd = 10'd0;
      w_exp_rnd = w_exp + 8'sd1;
    end else begin
      w_man_rnd = w_man_sum[9:0];
      w_exp_rnd = w_exp;
    end

    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_result = 16'h7C01;
    end else if (w_a_inf || w_b_zero) begin
      w_result = {w_sign, 5'd31, 10'd0};
    end else if (w_a_zero || w_b_inf) begin
      w_result = {w_sign, 15'd0};
    end else if (w_exp_rnd >= 8'sd31) begin
      w_result = {w_sign, 5'd31, 10'd0};
    end else if (w_exp_rnd <= 8'sd0) begin
      w_result = {w_sign, 15'd0};
    end else begin
      w_result = {w_sign, w_exp_rnd[4:0], w_man_rnd};
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_state_next = DIV;
      DIV:     if (r_cnt == 4'd12) w_state_next = ROUND;
      ROUND:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_rem   <= 12'd0;
      r_div   <= 11'd0;
      r_q     <= 13'd0;
      r_cnt   <= 4'd0;
      r_out   <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_rem <= {2'b01, A[9:0]};
            r_div <= {1'b1, B[9:0]};
            r_q   <= 13'd0;
            r_cnt <= 4'd0;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[11:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        ROUND:   r_out <= w_result;
        default: ;
      endcase
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_fp16_divider.sv
// Directed-vector bench for fp16_divider: latency, busy window, specials, range
// limits, ignored starts, operand latching and mid-operation reset.
module tb_fp16_divider;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int n_vec;
  int n_err;

  fp16_divider dut (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // mode 0: plain; mode 1: extra start pulses at n+3 and n+15; mode 2: operands scrambled every cycle
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_out, input int mode);
    int          done_at;
    int          busy_bad;
    int          extra;
    logic [15:0] got;
    done_at  = 0;
    busy_bad = 0;
    extra    = 0;
    got      = 16'h0000;
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (mode == 1) begin
        start = (k == 3) || (k == 15);
        A     = 16'h3C00;
        B     = 16'h4200;
      end
      if (mode == 2) begin
        A = 16'($urandom);
        B = 16'($urandom);
      end
      if (!busy) busy_bad++;
      if (done) begin
        if (done_at == 0) done_at = k;
        else extra++;
      end
      if (k == 15) got = out;
      @(posedge CLK); #1;
    end
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) extra++;
      if (busy) busy_bad++;
      @(posedge CLK); #1;
    end
    chk({tag, "_lat"},   done_at,  15);
    chk({tag, "_busy"},  busy_bad, 0);
    chk({tag, "_extra"}, extra,    0);
    chk({tag, "_out"},   got,      exp_out);
  endtask

  initial begin
    int stray;
    n_vec = 0;
    n_err = 0;
    RESET = 1'b1;
    start = 1'b1;
    A     = 16'h4000;
    B     = 16'h3C00;
    repeat (2) @(posedge CLK);
    #1;
    start = 1'b0;
    chk("rst_out",  out,  16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("rst_drop_busy", busy, 0);

    run_op("two_div_one",  16'h4000, 16'h3C00, 16'h4000, 0);
    run_op("one_third",    16'h3C00, 16'h4200, 16'h3555, 0);
    run_op("neg5_div_2",   16'hC500, 16'h4000, 16'hC100, 0);
    run_op("x_div_zero",   16'h3C00, 16'h0000, 16'h7C00, 0);
    run_op("zero_zero",    16'h0000, 16'h0000, 16'h7C01, 0);
    run_op("inf_inf",      16'h7C00, 16'h7C00, 16'h7C01, 0);
    run_op("negzero",      16'h8000, 16'h3C00, 16'h8000, 0);
    run_op("nan_in",       16'h7E00, 16'h3C00, 16'h7C01, 0);
    run_op("overflow",     16'h7BFF, 16'h0400, 16'h7C00, 0);
    run_op("underflow",    16'h0400, 16'h7BFF, 16'h0000, 0);
    run_op("subnorm",      16'h0001, 16'h3C00, 16'h0000, 0);
    run_op("start_ignore", 16'h4000, 16'h3C00, 16'h4000, 1);
    run_op("scramble",     16'hC500, 16'h4000, 16'hC100, 2);

    // Abort at n+7: out must clear from the previous 0xC100 result.
    start = 1'b1;
    A     = 16'h4000;
    B     = 16'h3C00;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("abort_out",  out,  16'h0000);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    stray = 0;
    for (int k = 0; k < 16; k++) begin
      if (done || busy) stray++;
      @(posedge CLK); #1;
    end
    chk("abort_quiet", stray, 0);
    run_op("after_abort", 16'h3C00, 16'h4200, 16'h3555, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
